ama_riscv_operand_stage: RTL and testbench

Decode-to-execute operand stage, directly downstream of the register file (`ama_riscv_reg_file`). It drives the register file read addresses and picks each operand from one of four sources: the execute-stage result, the writeback data, the asynchronous register file read data, or zero for x0. It detects load-use hazards and inserts bubbles for them. Results are registered into the ID/EX pipeline register under a valid/ready handshake with flush support.

---
 rtl/ama_riscv_operand_stage_if.sv | 54 +++++
 rtl/ama_riscv_operand_stage.sv | 96 +++++++++
 tb/tb_ama_riscv_operand_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_operand_stage_if.sv
// Bundle between the operand stage and its neighbours: decode, register file,
// writeback, and the execute stage. The operand stage is the slave side.
interface ama_riscv_operand_stage_if #(
    parameter int RF_AW = 5,
    parameter int DW    = 32,
    parameter int SCW   = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [RF_AW-1:0] id_rs1;
    logic [RF_AW-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RF_AW-1:0] id_rd;
    logic             id_rd_we;
    logic             id_is_load;
    logic [RF_AW-1:0] rf_addr_a;
    logic [RF_AW-1:0] rf_addr_b;
    logic [DW-1:0]    rf_data_a;
    logic [DW-1:0]    rf_data_b;
    logic [DW-1:0]    ex_alu_data;
    logic             wb_we;
    logic [RF_AW-1:0] wb_rd;
    logic [DW-1:0]    wb_data;
    logic             flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [DW-1:0]    ex_rs1_data;
    logic [DW-1:0]    ex_rs2_data;
    logic [RF_AW-1:0] ex_rd;
    logic             ex_rd_we;
    logic             ex_is_load;
    logic [SCW-1:0]   stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
               rf_data_a, rf_data_b, ex_alu_data,
               wb_we, wb_rd, wb_data, flush, ex_ready,
        input  id_ready, rf_addr_a, rf_addr_b,
               ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we,
               ex_is_load, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
               rf_data_a, rf_data_b, ex_alu_data,
               wb_we, wb_rd, wb_data, flush, ex_ready,
        output id_ready, rf_addr_a, rf_addr_b,
               ex_valid, ex_rs1_data, ex_rs2_data, ex_rd, ex_rd_we,
               ex_is_load, stall_cnt
    );
endinterface

// File: rtl/ama_riscv_operand_stage.sv
// ID->EX operand stage: forwarding mux (x0 / EX / WB / regfile), load-use bubble,
// 1-cycle registered output, valid/ready with flush; stalls ID while EX is held.
module ama_riscv_operand_stage #(
    parameter int RF_AW = 5,
    parameter int DW    = 32,
    parameter int SCW   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    ama_riscv_operand_stage_if.slave     io_bus
);
    logic             r_ex_valid;
    logic [DW-1:0]    r_ex_rs1_data;
    logic [DW-1:0]    r_ex_rs2_data;
    logic [RF_AW-1:0] r_ex_rd;
    logic             r_ex_rd_we;
    logic             r_ex_is_load;
    logic [SCW-1:0]   r_stall_cnt;

    logic             w_ex_fwd_ok;
    logic             w_hazard;
    logic             w_adv;
    logic [DW-1:0]    w_op_a;
    logic [DW-1:0]    w_op_b;

    assign io_bus.rf_addr_a = io_bus.id_rs1;
    assign io_bus.rf_addr_b = io_bus.id_rs2;

    // A load's data is not available in EX, so only ALU results forward from there.
    assign w_ex_fwd_ok = r_ex_valid & r_ex_rd_we & ~r_ex_is_load;

    always_comb begin
        w_op_a = io_bus.rf_data_a;
        if (io_bus.id_rs1 == '0)
            w_op_a = '0;
        else if (w_ex_fwd_ok && (r_ex_rd == io_bus.id_rs1))
            w_op_a = io_bus.ex_alu_data;
        else if (io_bus.wb_we && (io_bus.wb_rd == io_bus.id_rs1))
            w_op_a = io_bus.wb_data;
    end

    always_comb begin
        w_op_b = io_bus.rf_data_b;
        if (io_bus.id_rs2 == '0)
            w_op_b = '0;
        else if (w_ex_fwd_ok && (r_ex_rd == io_bus.id_rs2))
            w_op_b = io_bus.ex_alu_data;
        else if (io_bus.wb_we && (io_bus.wb_rd == io_bus.id_rs2))
            w_op_b = io_bus.wb_data;
    end

    assign w_hazard = io_bus.id_valid & r_ex_valid & r_ex_is_load & r_ex_rd_we &
                      (r_ex_rd != '0) &
                      ((io_bus.id_rs1_used & (io_bus.id_rs1 == r_ex_rd)) |
                       (io_bus.id_rs2_used & (io_bus.id_rs2 == r_ex_rd)));

    assign w_adv           = ~r_ex_valid | io_bus.ex_ready;
    assign io_bus.id_ready = io_bus.flush | (w_adv & ~w_hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_rd       <= '0;
            r_ex_rd_we    <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (io_bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_hazard) begin
                r_ex_valid <= 1'b0;
                if (r_stall_cnt != '1)
                    r_stall_cnt <= r_stall_cnt + 1'b1;
            end else if (io_bus.id_valid) begin
                r_ex_valid    <= 1'b1;
                r_ex_rs1_data <= w_op_a;
                r_ex_rs2_data <= w_op_b;
                r_ex_rd       <= io_bus.id_rd;
                r_ex_rd_we    <= io_bus.id_rd_we;
                r_ex_is_load  <= io_bus.id_is_load;
            end else begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign io_bus.ex_valid    = r_ex_valid;
    assign io_bus.ex_rs1_data = r_ex_rs1_data;
    assign io_bus.ex_rs2_data = r_ex_rs2_data;
    assign io_bus.ex_rd       = r_ex_rd;
    assign io_bus.ex_rd_we    = r_ex_rd_we;
    assign io_bus.ex_is_load  = r_ex_is_load;
    assign io_bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_ama_riscv_operand_stage.sv
// Directed bench for the operand stage: reset, forwarding priority, x0,
// load-use bubble, backpressure and flush.
module tb_ama_riscv_operand_stage;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ama_riscv_operand_stage_if #(.RF_AW(5), .DW(32), .SCW(16)) bus ();

    ama_riscv_operand_stage #(.RF_AW(5), .DW(32), .SCW(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic vld, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic we, input logic ld);
        bus.id_valid    = vld;
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
        bus.id_rd       = rd;
        bus.id_rd_we    = we;
        bus.id_is_load  = ld;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] dat);
        bus.wb_we   = we;
        bus.wb_rd   = rd;
        bus.wb_data = dat;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        bus.rf_data_a   = 32'h0;
        bus.rf_data_b   = 32'h0;
        bus.ex_alu_data = 32'h0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_stall", {16'd0, bus.stall_cnt}, 32'd0);
        rst = 1'b0;

        // Fill the output register, then reset asynchronously mid-cycle.
        set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
        bus.rf_data_a = 32'h11;
        bus.rf_data_b = 32'h22;
        chk("rf_addr_a", {27'd0, bus.rf_addr_a}, 32'd3);
        chk("rf_addr_b", {27'd0, bus.rf_addr_b}, 32'd4);
        tick();
        chk("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("pre_rst_rs2", bus.ex_rs2_data, 32'h22);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("arst_rs1", bus.ex_rs1_data, 32'h0);
        chk("arst_rs2", bus.ex_rs2_data, 32'h0);
        chk("arst_rd", {27'd0, bus.ex_rd}, 32'd0);
        chk("arst_rd_we", {31'd0, bus.ex_rd_we}, 32'd0);
        chk("arst_is_load", {31'd0, bus.ex_is_load}, 32'd0);
        #1 rst = 1'b0;
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        chk("first_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("first_rs1", bus.ex_rs1_data, 32'h11);
        chk("first_rd", {27'd0, bus.ex_rd}, 32'd3);

        // EX beats WB when both target the same register.
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        bus.ex_alu_data = 32'hAAAA;
        set_wb(1'b1, 5'd5, 32'hBBBB);
        bus.rf_data_a = 32'hCCCC;
        bus.rf_data_b = 32'hCCCC;
        tick();
        chk("fwd_ex_rs1", bus.ex_rs1_data, 32'hAAAA);
        chk("fwd_ex_rs2", bus.ex_rs2_data, 32'hAAAA);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("drain_valid", {31'd0, bus.ex_valid}, 32'd0);
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        chk("fwd_wb_rs1", bus.ex_rs1_data, 32'hBBBB);
        chk("fwd_wb_rs2", bus.ex_rs2_data, 32'hBBBB);

        // x0 always reads zero, even if EX and WB claim to write it.
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        bus.ex_alu_data = 32'hFFFF_FFFF;
        set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        bus.rf_data_a = 32'hFFFF_FFFF;
        bus.rf_data_b = 32'h0000_0222;
        tick();
        chk("x0_rs1", bus.ex_rs1_data, 32'h0);
        chk("x0_rs2_rf", bus.ex_rs2_data, 32'h222);

        // Load-use on rs2: one bubble, then WB supplies the loaded value.
        set_wb(1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        bus.rf_data_a = 32'h1;
        bus.rf_data_b = 32'hDEAD;
        #1;
        chk("lu_id_ready", {31'd0, bus.id_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
        chk("lu_stall", {16'd0, bus.stall_cnt}, 32'd1);
        set_wb(1'b1, 5'd7, 32'h1234);
        #1;
        chk("lu_id_ready2", {31'd0, bus.id_ready}, 32'd1);
        tick();
        chk("lu_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("lu_rs2_wb", bus.ex_rs2_data, 32'h1234);
        chk("lu_rd", {27'd0, bus.ex_rd}, 32'd8);
        chk("lu_stall_hold", {16'd0, bus.stall_cnt}, 32'd1);

        // Unused rs2 matching the load destination does not stall.
        set_wb(1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0);
        bus.rf_data_b = 32'h77;
        #1;
        chk("unused_id_ready", {31'd0, bus.id_ready}, 32'd1);
        tick();
        chk("unused_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("unused_rs2", bus.ex_rs2_data, 32'h77);
        chk("unused_stall", {16'd0, bus.stall_cnt}, 32'd1);

        // Backpressure: output holds, ID is not accepted.
        bus.ex_ready = 1'b0;
        set_id(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        bus.rf_data_a = 32'h99;
        bus.rf_data_b = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", {31'd0, bus.id_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'd0, bus.ex_valid}, 32'd1);
            chk("bp_rd", {27'd0, bus.ex_rd}, 32'd8);
            chk("bp_rs2", bus.ex_rs2_data, 32'h77);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("bp_release_rd", {27'd0, bus.ex_rd}, 32'd9);
        chk("bp_release_rs1", bus.ex_rs1_data, 32'h99);

        // Held load: stall persists, but counts only the one real bubble.
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        bus.ex_ready = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bpl_id_ready", {31'd0, bus.id_ready}, 32'd0);
            tick();
            chk("bpl_stall", {16'd0, bus.stall_cnt}, 32'd1);
            chk("bpl_load_held", {31'd0, bus.ex_is_load}, 32'd1);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("bpl_bubble", {31'd0, bus.ex_valid}, 32'd0);
        chk("bpl_stall2", {16'd0, bus.stall_cnt}, 32'd2);
        set_wb(1'b1, 5'd7, 32'h5678);
        tick();
        chk("bpl_valid", {31'd0, bus.ex_valid}, 32'd1);
        chk("bpl_rs1_wb", bus.ex_rs1_data, 32'h5678);
        chk("bpl_stall3", {16'd0, bus.stall_cnt}, 32'd2);

        // Flush overrides a pending hazard and does not count a bubble.
        set_wb(1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("fl_id_ready", {31'd0, bus.id_ready}, 32'd1);
        tick();
        chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("fl_stall", {16'd0, bus.stall_cnt}, 32'd2);
        bus.flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
